counter_sequencer: RTL
======================

# counter_sequencer

Run controller for the 4-bit counter datapath. It loads a seed into up to three counter implementations (behavioural, logic-level, switch-level), then issues a programmable train of count-enable pulses. A lockstep reference model checks every cycle that all three implementations agree with it. It sits between the bench or top level and the counters, replacing hand-written CE/RST waveforms with a repeatable, self-checking sequence.

## Interface
Parameters:
- W, 4, counter width
- DIV_W, 4, width of CE divider setting
- LEN_W, 8, width of pulse-count setting

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  begin a run; sampled only in IDLE, DONE or ERROR
- SEED  in  W  value loaded into counters
- DIV  in  DIV_W  CE asserted one cycle every DIV+1 cycles
- LEN  in  LEN_W  number of CE pulses in the run
- CNT_A, CNT_B, CNT_C  in  W  outputs of the three counter implementations
- CE  out  1  count enable to all counters
- LD  out  1  load strobe; counters take LD_VAL on the rising edge while LD=1
- LD_VAL  out  W  seed captured at START
- EXPECT  out  W  reference model value
- BUSY  out  1  run in progress (LOAD/RUN/DRAIN)
- DONE  out  1  one-cycle pulse on clean completion
- ERR  out  1  sticky mismatch flag
- ERR_STEP  out  LEN_W  CE pulses issued when the mismatch was detected

## Operation
- Counter contract: registered; LD has priority; CE=1 increments by 1 mod 2^W.
- States: IDLE, LOAD, RUN, DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR + START=1 → LOAD. Capture SEED→LD_VAL, LEN, DIV. Clear ERR, ERR_STEP, step count, divider.
- LOAD, one cycle: LD=1, BUSY=1. At end: EXPECT←SEED. Next state is RUN if LEN≠0, else DRAIN.
- RUN: divider counts 0..DIV. On the cycle with divcnt==DIV, CE=1, divcnt←0, step+1, EXPECT←EXPECT+1 (wraps 2^W−1→0). After the LEN-th pulse → DRAIN.
- DRAIN, one cycle: final compare.
- DONE, one cycle: DONE=1. Then IDLE unless START=1.
- Compare: in RUN and DRAIN, the mismatch condition is any of CNT_A/B/C ≠ EXPECT. A mismatch is registered: next cycle ERR=1, ERR_STEP=step value at detection, state→ERROR. The run stops; CE and LD stay 0.
- ERROR holds ERR until START or RST.
- START in LOAD/RUN/DRAIN is ignored. DIV and LEN changes mid-run are ignored because they are captured at START.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.

## Timing
- Reset (async, immediate): state IDLE. CE, LD, BUSY, DONE, ERR = 0. LD_VAL, EXPECT, ERR_STEP = 0. Divider and step count = 0.
- RST asserted mid-run aborts at once. CE and LD drop without waiting for a clock. No DONE or ERR is produced.
- Run timeline with START sampled in cycle 0:
  - LD=1 in cycle 1.
  - RUN starts in cycle 2.
  - k-th CE is in cycle 2+k·(DIV+1)−1.
  - DRAIN is the cycle after the last CE.
  - DONE is one cycle after DRAIN.
- Total cycles from START to DONE = LEN·(DIV+1)+3.
- DIV=0 gives CE high on consecutive cycles.
- Mismatch detected in cycle n → ERR=1 from cycle n+1. ERR takes precedence over DONE if detected in DRAIN.

## Test plan
- Ideal counters, SEED=0101, DIV=1, LEN=6:
  - CE in cycles 3,5,7,9,11,13.
  - DONE pulse in cycle 15.
  - EXPECT=CNT_*=1011.
  - ERR=0.
- Wrap, SEED=1110, DIV=0, LEN=3:
  - CE in cycles 2,3,4.
  - EXPECT 1111→0000→0001.
  - DONE in cycle 6, no ERR.
- Fault, CNT_B stuck at 0101, SEED=0101, DIV=1, LEN=6:
  - mismatch seen in cycle 4.
  - ERR=1 and ERR_STEP=1 from cycle 5.
  - no further CE.
  - START then clears ERR.
- LEN=0, SEED=0011: LD in cycle 1, DRAIN in cycle 2, DONE in cycle 3, no CE.
- RST=1 in cycle 8 of the first scenario:
  - all outputs 0 immediately.
  - after release, START gives a full clean run with DONE after 15 cycles.
- START pulsed in cycle 6 of a run: ignored, and CE timing is unchanged.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: loads a seed into three counter implementations, issues a CE pulse train
// and checks every cycle that all three track a lockstep reference model.
module counter_sequencer #(
    parameter int W     = 4,
    parameter int DIV_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [W-1:0]     SEED,
    input  logic [DIV_W-1:0] DIV,
    input  logic [LEN_W-1:0] LEN,
    input  logic [W-1:0]     CNT_A,
    input  logic [W-1:0]     CNT_B,
    input  logic [W-1:0]     CNT_C,
    output logic             CE,
    output logic             LD,
    output logic [W-1:0]     LD_VAL,
    output logic [W-1:0]     EXPECT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [LEN_W-1:0] ERR_STEP
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE, S_ERROR} state_t;
    state_t state, next;
    logic [DIV_W-1:0] div_r, div_cnt;
    logic [LEN_W-1:0] len_r, step;
    logic tick, mismatch, launch;
    assign launch   = START && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign tick     = state == S_RUN && div_cnt == div_r;
    assign mismatch = (state == S_RUN || state == S_DRAIN) &&
                      (CNT_A != EXPECT || CNT_B != EXPECT || CNT_C != EXPECT);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE: next = START ? S_LOAD : S_IDLE;
            S_ERROR:        next = START ? S_LOAD : S_ERROR;
            S_LOAD:         next = len_r != '0 ? S_RUN : S_DRAIN;
            S_RUN:          next = mismatch ? S_ERROR :
                                   (tick && step + LEN_W'(1) == len_r) ? S_DRAIN : S_RUN;
            S_DRAIN:        next = mismatch ? S_ERROR : S_DONE;
            default:        next = S_IDLE;
        endcase
    end
    always_comb begin
        CE   = tick;
        LD   = state == S_LOAD;
        BUSY = state == S_LOAD || state == S_RUN || state == S_DRAIN;
        DONE = state == S_DONE;
        ERR  = state == S_ERROR;
    end
    // Run settings are frozen at launch so mid-run input changes cannot disturb the sequence.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LD_VAL   <= '0;
            EXPECT   <= '0;
            ERR_STEP <= '0;
            len_r    <= '0;
            div_r    <= '0;
            div_cnt  <= '0;
            step     <= '0;
        end else begin
            if (launch) begin
                LD_VAL   <= SEED;
                len_r    <= LEN;
                div_r    <= DIV;
                div_cnt  <= '0;
                step     <= '0;
                ERR_STEP <= '0;
            end
            if (state == S_LOAD) EXPECT <= LD_VAL;
            if (state == S_RUN) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    step   <= step + 1'b1;
                    EXPECT <= EXPECT + 1'b1;
                end
            end
            if (mismatch) ERR_STEP <= step;
        end
    end
endmodule
